ysyx_22040750_if_id: RTL and testbench
======================================

// Module: ysyx_22040750_if_id
// PURPOSE
//  IF->ID pipeline stage directly downstream of the PC/fetch stage. Accepts {pc,inst} on a valid/allowin
//  handshake, buffers up to 2 entries (skid FIFO) so O_IF_ID_allowin has no combinational path from ID_EX,
//  predecodes register indices and sign-extended immediate, and presents them to ID with a valid/allowin pair.
// PARAMETERS
//  XLEN   64  width of generated immediate
//  PC_W   32  width of pc
//  DEPTH  2   skid entries (only 2 supported; ptrs are 1 bit)
// PORTS
//  I_sys_clk        in   1     clock, all state on posedge
//  I_rst_n          in   1     asynchronous active-low reset
//  I_IF_valid       in   1     fetch stage holds a valid {pc,inst}
//  I_pc             in   PC_W  pc of fetched inst
//  I_inst           in   32    fetched instruction
//  O_IF_ID_allowin  out  1     stage can accept this cycle
//  I_flush          in   1     redirect from EX/branch/fencei: drop all buffered and incoming entries
//  I_ID_EX_allowin  in   1     consumer accepts head this cycle
//  O_ID_valid       out  1     head entry valid
//  O_pc             out  PC_W  head pc
//  O_inst           out  32    head inst
//  O_rs1/O_rs2/O_rd out  5     inst[19:15]/[24:20]/[11:7]
//  O_rs1_en/O_rs2_en/O_rd_en out 1  register actually read/written per format (hazard unit)
//  O_imm            out  XLEN  sign-extended immediate, 0 for R-type/unknown
//  O_illegal        out  1     opcode not in supported RV64I/M + SYSTEM/FENCE set
// BEHAVIOUR
//  - Reset (I_rst_n=0, async): count=0, wr_ptr=rd_ptr=0, entries' valid=0; O_ID_valid=0, O_IF_ID_allowin=1,
//    O_pc=0, O_inst=32'h0000_0013 (NOP); decode outputs follow O_inst. Deassertion sampled synchronously.
//  - push = I_IF_valid & O_IF_ID_allowin & ~I_flush; pop = O_ID_valid & I_ID_EX_allowin & ~I_flush.
//  - O_IF_ID_allowin = (count != 2); depends on registered count only.
//  - O_ID_valid = (count != 0); head = entry[rd_ptr]; decode is combinational on head (0 cycle added).
//  - Latency: pushed at edge N -> visible at head after edge N when FIFO was empty (1 cycle IF->ID).
//  - count update: push&~pop +1; pop&~push -1; push&pop unchanged (count==1 case; count==2 cannot push;
//    count==0 cannot pop). Pointers wrap modulo 2.
//  - I_flush: at the edge count<=0, ptrs<=0; incoming push and any pop are discarded same cycle;
//    allowin=1 the following cycle. Flush with count==0 is harmless.
//  - Ordering strictly FIFO; no entry duplicated or lost except by flush.
//  - Stall: I_ID_EX_allowin=0 holds head outputs stable (pc, inst, all decode) until popped or flushed.
//  - Imm by opcode[6:0]: I(0000011,0010011,0011011,1100111,1110011), S(0100011), B(1100011),
//    U(0110111,0010111), J(1101111); R/others -> 0. Sign bit inst[31] extended to XLEN.
//  - rs1_en: I,S,B,R; rs2_en: S,B,R; rd_en: R,I(except 1110011 with rd==0),U,J and rd!=0.
//  - O_illegal=1 only when O_ID_valid=1 and opcode unsupported; otherwise 0.
// STRUCTURE
//  - Shared package ysyx_22040750_defs: opcode localparams, NOP constant, imm-type enum {IMM_I,IMM_S,IMM_B,
//    IMM_U,IMM_J,IMM_NONE}.
//  - Sub-module ysyx_22040750_imm_gen (combinational: inst -> imm_type, O_imm, reg enables, illegal).
//  - Top holds the 2-entry {pc,inst} array, pointers, count, handshake logic.
// TESTING
//  1 Reset mid-traffic: count=2, pull I_rst_n low between edges -> O_ID_valid=0, allowin=1 immediately.
//  2 Streaming: push pc 0x80000000..0x8000000C each cycle, ID_EX_allowin=1 -> each head 1 cycle later,
//    allowin stays 1, order preserved.
//  3 Backpressure: ID_EX_allowin=0, push 3 insts -> allowin=0 after 2nd, 3rd held upstream; release ->
//    pops 0x80000000,0x80000004 then 3rd accepted.
//  4 Flush with count=2 and I_IF_valid=1 same cycle -> next cycle O_ID_valid=0, allowin=1, incoming dropped.
//  5 Decode: inst 0xFFF00093 (addi x1,x0,-1) -> imm=64'hFFFF_FFFF_FFFF_FFFF, rd=1, rs1_en=1, rs2_en=0;
//    0xFE000EE3 (beq x0,x0,-4) -> imm=-4, rd_en=0; 0x0000007F -> O_illegal=1.
//  6 Simultaneous push+pop at count=1 over 10 cycles -> count stays 1, each entry seen exactly once.

Source files
------------

// File: rtl/ysyx_22040750_defs.sv
// ysyx_22040750_defs
//   Shared definitions for the IF->ID stage: RV64I/M opcodes, the NOP that
//   an empty/reset stage presents, and the immediate-format enum used by
//   the predecoder.
package ysyx_22040750_defs;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

endpackage

// File: rtl/ysyx_22040750_imm_gen.sv
// ysyx_22040750_imm_gen
//   Combinational predecoder: classifies the opcode, builds the
//   sign-extended immediate and the register-use enables for the hazard unit.
// Ports
//   inst     in   32    instruction to predecode
//   imm      out  XLEN  sign-extended immediate (0 for R-type / FENCE / unknown)
//   rs1_en   out  1     rs1 is read
//   rs2_en   out  1     rs2 is read
//   rd_en    out  1     rd is written (never for x0)
//   illegal  out  1     opcode outside the supported set (not gated by valid)
module ysyx_22040750_imm_gen
  import ysyx_22040750_defs::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            rs1_en,
  output logic            rs2_en,
  output logic            rd_en,
  output logic            illegal
);

  imm_type_e   imm_type;
  logic        is_rtype;
  logic [31:0] imm32;
  logic        rd_nz;

  assign rd_nz = (inst[11:7] != 5'd0);

  always_comb begin
    imm_type = IMM_NONE;
    is_rtype = 1'b0;
    illegal  = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:              imm_type = IMM_S;
      OPC_BRANCH:             imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:     imm_type = IMM_U;
      OPC_JAL:                imm_type = IMM_J;
      OPC_OP, OPC_OP32:       is_rtype = 1'b1;
      OPC_FENCE:              imm_type = IMM_NONE;
      default:                illegal  = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = 32'd0;
    case (imm_type)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'd0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // every format above is already sign-extended to 32 bits
  assign imm = {{(XLEN-32){imm32[31]}}, imm32};

  always_comb begin
    rs1_en = 1'b0;
    rs2_en = 1'b0;
    rd_en  = 1'b0;
    case (imm_type)
      IMM_I: begin
        rs1_en = 1'b1;
        // covers csr ops / ecall with rd==x0 as well
        rd_en  = rd_nz;
      end
      IMM_S, IMM_B: begin
        rs1_en = 1'b1;
        rs2_en = 1'b1;
      end
      IMM_U, IMM_J: rd_en = rd_nz;
      default: begin
        if (is_rtype) begin
          rs1_en = 1'b1;
          rs2_en = 1'b1;
          rd_en  = rd_nz;
        end
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_if_id.sv
// ysyx_22040750_if_id
//   IF->ID pipeline stage. A 2-entry skid FIFO holds {pc,inst} so that
//   O_IF_ID_allowin depends only on the registered occupancy, never on
//   I_ID_EX_allowin. The head entry is predecoded combinationally.
// Ports
//   I_sys_clk, I_rst_n            clock / async active-low reset
//   I_IF_valid, I_pc, I_inst      upstream entry offered
//   O_IF_ID_allowin               stage has room (count != 2)
//   I_flush                       drop all buffered and incoming entries
//   I_ID_EX_allowin               consumer takes the head this cycle
//   O_ID_valid, O_pc, O_inst      head entry
//   O_rs1/O_rs2/O_rd (+ _en)      register fields and their use enables
//   O_imm                         sign-extended immediate
//   O_illegal                     unsupported opcode on a valid head
module ysyx_22040750_if_id
  import ysyx_22040750_defs::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_IF_valid,
  input  logic [PC_W-1:0] I_pc,
  input  logic [31:0]     I_inst,
  output logic            O_IF_ID_allowin,
  input  logic            I_flush,
  input  logic            I_ID_EX_allowin,
  output logic            O_ID_valid,
  output logic [PC_W-1:0] O_pc,
  output logic [31:0]     O_inst,
  output logic [4:0]      O_rs1,
  output logic [4:0]      O_rs2,
  output logic [4:0]      O_rd,
  output logic            O_rs1_en,
  output logic            O_rs2_en,
  output logic            O_rd_en,
  output logic [XLEN-1:0] O_imm,
  output logic            O_illegal
);

  // pointers are a single bit, so only a depth of 2 is meaningful
  localparam logic [1:0] FULL = DEPTH[1:0];

  logic [PC_W-1:0] pc_q   [2];
  logic [31:0]     inst_q [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            illegal_raw;

  assign O_IF_ID_allowin = (count != FULL);
  assign O_ID_valid      = (count != 2'd0);

  assign push = I_IF_valid & O_IF_ID_allowin & ~I_flush;
  assign pop  = O_ID_valid & I_ID_EX_allowin & ~I_flush;

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= INST_NOP;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (I_flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= I_pc;
        inst_q[wr_ptr] <= I_inst;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign O_pc   = pc_q[rd_ptr];
  assign O_inst = inst_q[rd_ptr];
  assign O_rs1  = O_inst[19:15];
  assign O_rs2  = O_inst[24:20];
  assign O_rd   = O_inst[11:7];

  ysyx_22040750_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .inst    (O_inst),
    .imm     (O_imm),
    .rs1_en  (O_rs1_en),
    .rs2_en  (O_rs2_en),
    .rd_en   (O_rd_en),
    .illegal (illegal_raw)
  );

  assign O_illegal = O_ID_valid & illegal_raw;

endmodule

// File: tb/tb_ysyx_22040750_if_id.sv
module tb_ysyx_22040750_if_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        allowin;
  logic        flush;
  logic        ready;
  logic        id_valid;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_en, rs2_en, rd_en;
  logic [63:0] imm;
  logic        illegal;

  always #5 clk = ~clk;

  ysyx_22040750_if_id #(.XLEN(64), .PC_W(32), .DEPTH(2)) dut (
    .I_sys_clk       (clk),
    .I_rst_n         (rst_n),
    .I_IF_valid      (if_valid),
    .I_pc            (pc),
    .I_inst          (inst),
    .O_IF_ID_allowin (allowin),
    .I_flush         (flush),
    .I_ID_EX_allowin (ready),
    .O_ID_valid      (id_valid),
    .O_pc            (o_pc),
    .O_inst          (o_inst),
    .O_rs1           (rs1),
    .O_rs2           (rs2),
    .O_rd            (rd),
    .O_rs1_en        (rs1_en),
    .O_rs2_en        (rs2_en),
    .O_rd_en         (rd_en),
    .O_imm           (imm),
    .O_illegal       (illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // one clock: compare against the model at negedge, then advance the model
  task automatic cyc();
    bit mv, ma;
    @(negedge clk);
    mv = (q.size() != 0);
    ma = (q.size() != 2);
    chk("id_valid", {63'd0, id_valid}, {63'd0, mv});
    chk("allowin", {63'd0, allowin}, {63'd0, ma});
    if (mv) begin
      chk("head_pc", {32'd0, o_pc}, {32'd0, q[0].pc});
      chk("head_inst", {32'd0, o_inst}, {32'd0, q[0].inst});
    end
    acc = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (mv && ready) void'(q.pop_front());
      if (if_valid && ma) begin
        q.push_back('{pc, inst});
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_and_hold(input logic [31:0] p, input logic [31:0] i);
    ready = 1'b0; if_valid = 1'b1; pc = p; inst = i;
    cyc();
    if_valid = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1; if_valid = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; pc = '0; inst = '0; flush = 1'b0; ready = 1'b0;
    #12;
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_allowin", {63'd0, allowin}, 64'd1);
    chk("rst_pc", {32'd0, o_pc}, 64'd0);
    chk("rst_inst", {32'd0, o_inst}, 64'h13);
    chk("rst_imm", imm, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // streaming with the consumer always ready
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_valid = 1'b1;
      pc   = 32'h8000_0000 + 32'(4 * k);
      inst = 32'h0010_0093 + 32'(k << 20);
      cyc();
      chk("stream_accept", {63'd0, acc}, 64'd1);
    end
    drain();

    // backpressure: third entry waits upstream until space frees
    begin
      int k = 0;
      ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (c == 4) ready = 1'b1;
        if (c == 2) chk("bp_allowin_low", {63'd0, allowin}, 64'd0);
        if_valid = (k < 3);
        pc   = 32'h8000_0000 + 32'(4 * k);
        inst = 32'h0000_0113 + 32'(k << 20);
        cyc();
        if (acc) k++;
      end
      chk("bp_all_accepted", 64'(k), 64'd3);
    end
    drain();

    // flush while full with an incoming entry
    push_and_hold(32'h9000_0000, 32'h0000_0093);
    push_and_hold(32'h9000_0004, 32'h0000_0113);
    flush = 1'b1; if_valid = 1'b1; pc = 32'h9000_0008; inst = 32'h0000_0193;
    cyc();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", {63'd0, id_valid}, 64'd0);
    chk("flush_allowin", {63'd0, allowin}, 64'd1);
    cyc();

    // async reset while full
    push_and_hold(32'hA000_0000, 32'h0000_0093);
    push_and_hold(32'hA000_0004, 32'h0000_0113);
    #2; rst_n = 1'b0; #1;
    chk("midrst_valid", {63'd0, id_valid}, 64'd0);
    chk("midrst_allowin", {63'd0, allowin}, 64'd1);
    chk("midrst_pc", {32'd0, o_pc}, 64'd0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // predecode
    push_and_hold(32'hB000_0000, 32'hFFF0_0093);
    chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rd", {59'd0, rd}, 64'd1);
    chk("addi_rs1", {59'd0, rs1}, 64'd0);
    chk("addi_rs1_en", {63'd0, rs1_en}, 64'd1);
    chk("addi_rs2_en", {63'd0, rs2_en}, 64'd0);
    chk("addi_rd_en", {63'd0, rd_en}, 64'd1);
    chk("addi_illegal", {63'd0, illegal}, 64'd0);
    drain();
    push_and_hold(32'hB000_0004, 32'hFE00_0EE3);
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rd_en", {63'd0, rd_en}, 64'd0);
    chk("beq_rs2_en", {63'd0, rs2_en}, 64'd1);
    drain();
    push_and_hold(32'hB000_0008, 32'h0000_007F);
    chk("bad_illegal", {63'd0, illegal}, 64'd1);
    chk("bad_imm", imm, 64'd0);
    drain();
    chk("empty_illegal", {63'd0, illegal}, 64'd0);

    // push and pop together at count==1
    push_and_hold(32'hC000_0000, 32'h0000_0093);
    ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if_valid = 1'b1;
      pc   = 32'hC000_0000 + 32'(4 * k);
      inst = 32'h0000_0093 + 32'(k << 20);
      cyc();
      chk("pp_count1", 64'(q.size()), 64'd1);
    end
    drain();
    chk("pp_drained", {63'd0, id_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
